// File: rtl/blake2s_pkg.sv
// Shared constants and state encodings for the BLAKE2s message block buffer.
package blake2s_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned NWORDS      = 16;
  localparam int unsigned T_W         = 64;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned BLOCK_W     = NWORDS * WORD_W;

  typedef enum logic {
    StFilling,
    StFull
  } fill_state_e;

  typedef enum logic {
    StEmpty,
    StValid
  } out_state_e;

endpackage

// File: rtl/blake2s_msg_buf_if.sv
// Byte-stream input and block-output signals of the BLAKE2s message buffer.
interface blake2s_msg_buf_if;
  import blake2s_pkg::*;

  logic                   data_v_i;
  logic [7:0]             data_i;
  logic [IDX_W-1:0]       data_idx_i;
  logic                   block_first_i;
  logic                   block_last_i;
  logic [5:0]             kk_i;
  logic [T_W-1:0]         ll_i;
  logic                   ready_o;
  logic                   blk_v_o;
  logic                   blk_ready_i;
  logic [BLOCK_W-1:0]     m_o;
  logic [T_W-1:0]         t_o;
  logic                   last_o;
  logic                   err_o;

  // Buffer side.
  modport slave (
    input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i, kk_i, ll_i, blk_ready_i,
    output ready_o, blk_v_o, m_o, t_o, last_o, err_o
  );

  // Host / core side.
  modport master (
    output data_v_i, data_i, data_idx_i, block_first_i, block_last_i, kk_i, ll_i, blk_ready_i,
    input  ready_o, blk_v_o, m_o, t_o, last_o, err_o
  );

endinterface

// File: rtl/msg_word_packer.sv
// Byte-addressed register file read back as little-endian packed message words.
module msg_word_packer #(
  parameter int unsigned NumBytes = 64,
  parameter int unsigned WordW    = 32,
  parameter int unsigned IdxW     = $clog2(NumBytes)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  we_i,
  input  logic [IdxW-1:0]       idx_i,
  input  logic [7:0]            byte_i,
  output logic [NumBytes*8-1:0] data_o
);

  localparam int unsigned BytesPerWord = WordW / 8;
  localparam int unsigned NumWords     = NumBytes / BytesPerWord;

  logic [7:0] mem_q [NumBytes];
  logic [7:0] mem_d [NumBytes];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[idx_i] = byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Byte b of word w lands in bits [8*b+:8] of that word.
  always_comb begin
    data_o = '0;
    for (int w = 0; w < NumWords; w++) begin
      for (int b = 0; b < BytesPerWord; b++) begin
        data_o[w*WordW + 8*b +: 8] = mem_q[w*BytesPerWord + b];
      end
    end
  end

endmodule

// File: rtl/blake2s_msg_buf.sv
// Collects the host byte stream into 64-byte BLAKE2s blocks; a fill stage and an output
// stage let the next block stream in while the compression core holds the current one.
module blake2s_msg_buf #(
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned WORD_W      = 32
) (
  input logic              clk,
  input logic              nreset,
  blake2s_msg_buf_if.slave bus
);
  import blake2s_pkg::T_W;
  import blake2s_pkg::fill_state_e;
  import blake2s_pkg::out_state_e;
  import blake2s_pkg::StFilling;
  import blake2s_pkg::StFull;
  import blake2s_pkg::StEmpty;
  import blake2s_pkg::StValid;

  localparam int unsigned    IdxW     = $clog2(BLOCK_BYTES);
  localparam int unsigned    BlockW   = BLOCK_BYTES * 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_BYTES - 1);
  localparam logic [T_W-1:0] BlockInc = T_W'(BLOCK_BYTES);

  fill_state_e         fill_q, fill_d;
  out_state_e          out_q, out_d;
  logic [IdxW-1:0]     exp_q, exp_d;
  logic                last_fill_q, last_fill_d;
  logic [T_W-1:0]      t_acc_q, t_acc_d;
  logic                err_q, err_d;
  logic [BlockW-1:0]   m_q, m_d;
  logic [T_W-1:0]      t_q, t_d;
  logic                last_q, last_d;

  logic                byte_ok;
  logic                is_end;
  logic                fast_xfer;
  logic                slow_xfer;
  logic                xfer_last;
  logic [BlockW-1:0]   xfer_data;
  logic [T_W-1:0]      xfer_t;
  logic [BlockW-1:0]   fill_data;

  msg_word_packer #(
    .NumBytes (BLOCK_BYTES),
    .WordW    (WORD_W),
    .IdxW     (IdxW)
  ) u_packer (
    .clk    (clk),
    .nreset (nreset),
    .we_i   (byte_ok),
    .idx_i  (bus.data_idx_i),
    .byte_i (bus.data_i),
    .data_o (fill_data)
  );

  always_comb begin
    byte_ok   = bus.data_v_i && (fill_q == StFilling) && (bus.data_idx_i == exp_q);
    is_end    = (bus.data_idx_i == LastIdx);
    // Closing byte with an empty output stage bypasses FULL so the block shows up next cycle.
    fast_xfer = byte_ok && is_end && (out_q == StEmpty);
    slow_xfer = (fill_q == StFull) && ((out_q == StEmpty) || bus.blk_ready_i);

    xfer_last = fast_xfer ? bus.block_last_i : last_fill_q;
    // Byte 63 is the top byte of the packed block and is not yet in the register file.
    xfer_data = fast_xfer ? {bus.data_i, fill_data[BlockW-9:0]} : fill_data;
    xfer_t    = xfer_last ? (bus.ll_i + ((bus.kk_i != '0) ? BlockInc : '0))
                          : (t_acc_q + BlockInc);
  end

  always_comb begin
    fill_d      = fill_q;
    out_d       = out_q;
    exp_d       = exp_q;
    last_fill_d = last_fill_q;
    t_acc_d     = t_acc_q;
    err_d       = err_q;
    m_d         = m_q;
    t_d         = t_q;
    last_d      = last_q;

    if (bus.data_v_i && !byte_ok) begin
      err_d = 1'b1;
    end
    if (bus.data_v_i && bus.block_first_i && (bus.data_idx_i != '0)) begin
      err_d = 1'b1;
    end

    if (byte_ok) begin
      exp_d = exp_q + IdxW'(1);
      if (bus.block_first_i && (bus.data_idx_i == '0)) begin
        t_acc_d = '0;
      end
      if (is_end) begin
        exp_d = '0;
        if (!fast_xfer) begin
          fill_d      = StFull;
          last_fill_d = bus.block_last_i;
        end
      end
    end

    if (fast_xfer || slow_xfer) begin
      out_d  = StValid;
      m_d    = xfer_data;
      t_d    = xfer_t;
      last_d = xfer_last;
      if (!xfer_last) begin
        t_acc_d = t_acc_q + BlockInc;
      end
      if (slow_xfer) begin
        fill_d = StFilling;
        exp_d  = '0;
      end
    end else if ((out_q == StValid) && bus.blk_ready_i) begin
      out_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fill_q      <= StFilling;
      out_q       <= StEmpty;
      exp_q       <= '0;
      last_fill_q <= 1'b0;
      t_acc_q     <= '0;
      err_q       <= 1'b0;
      m_q         <= '0;
      t_q         <= '0;
      last_q      <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_q       <= out_d;
      exp_q       <= exp_d;
      last_fill_q <= last_fill_d;
      t_acc_q     <= t_acc_d;
      err_q       <= err_d;
      m_q         <= m_d;
      t_q         <= t_d;
      last_q      <= last_d;
    end
  end

  assign bus.ready_o = (fill_q != StFull);
  assign bus.blk_v_o = (out_q == StValid);
  assign bus.m_o     = m_q;
  assign bus.t_o     = t_q;
  assign bus.last_o  = last_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_blake2s_msg_buf.sv
// Directed bench for blake2s_msg_buf with hand-computed block contents and t values.
module tb_blake2s_msg_buf;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic ready_low_seen = 1'b0;
  logic [7:0]   pat [64];
  logic [511:0] blk_a;
  logic [511:0] blk_b;

  blake2s_msg_buf_if bus ();

  blake2s_msg_buf dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] val, input logic first,
                           input logic last);
    bus.data_v_i      = 1'b1;
    bus.data_idx_i    = 6'(idx);
    bus.data_i        = val;
    bus.block_first_i = first;
    bus.block_last_i  = last;
    step();
    bus.data_v_i      = 1'b0;
    bus.block_first_i = 1'b0;
    bus.block_last_i  = 1'b0;
    if (!bus.ready_o) ready_low_seen = 1'b1;
  endtask

  task automatic send_range(input int lo, input int hi, input logic first, input logic last);
    for (int i = lo; i <= hi; i++) begin
      send_byte(i, pat[i], first && (i == 0), last);
    end
  endtask

  function automatic logic [511:0] pat_m();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = pat[i];
    return r;
  endfunction

  initial begin
    bus.data_v_i      = 1'b0;
    bus.data_i        = '0;
    bus.data_idx_i    = '0;
    bus.block_first_i = 1'b0;
    bus.block_last_i  = 1'b0;
    bus.kk_i          = '0;
    bus.ll_i          = '0;
    bus.blk_ready_i   = 1'b0;

    // Reset values
    step();
    step();
    check("rst_blk_v", bus.blk_v_o, 0);
    check("rst_ready", bus.ready_o, 1);
    check("rst_err", bus.err_o, 0);
    check("rst_last", bus.last_o, 0);
    check("rst_t", bus.t_o, 0);
    check("rst_m", bus.m_o, 0);
    nreset = 1'b1;
    step();

    // Unkeyed single block "abc"
    bus.kk_i = 6'd0;
    bus.ll_i = 64'd3;
    for (int i = 0; i < 64; i++) pat[i] = 8'h00;
    pat[0] = 8'h61; pat[1] = 8'h62; pat[2] = 8'h63;
    send_range(0, 62, 1'b1, 1'b1);
    check("abc_no_early_blk", bus.blk_v_o, 0);
    send_range(63, 63, 1'b1, 1'b1);
    check("abc_blk_v", bus.blk_v_o, 1);
    check("abc_m", bus.m_o, 512'h00636261);
    check("abc_t", bus.t_o, 3);
    check("abc_last", bus.last_o, 1);
    check("abc_ready", bus.ready_o, 1);
    step();
    check("abc_hold_v", bus.blk_v_o, 1);
    check("abc_hold_m", bus.m_o, 512'h00636261);
    bus.blk_ready_i = 1'b1;
    step();
    check("abc_pop", bus.blk_v_o, 0);

    // Three-block stream with the core always ready
    bus.ll_i = 64'd150;
    for (int i = 0; i < 64; i++) pat[i] = 8'(i);
    ready_low_seen = 1'b0;
    send_range(0, 63, 1'b1, 1'b0);
    check("s1_v", bus.blk_v_o, 1);
    check("s1_t", bus.t_o, 64);
    check("s1_last", bus.last_o, 0);
    check("s1_w0", bus.m_o[31:0], 32'h03020100);
    check("s1_m", bus.m_o, pat_m());
    send_range(0, 63, 1'b0, 1'b0);
    check("s2_v", bus.blk_v_o, 1);
    check("s2_t", bus.t_o, 128);
    check("s2_last", bus.last_o, 0);
    check("s2_w0", bus.m_o[31:0], 32'h03020100);
    send_range(0, 63, 1'b0, 1'b1);
    check("s3_v", bus.blk_v_o, 1);
    check("s3_t", bus.t_o, 150);
    check("s3_last", bus.last_o, 1);
    check("s3_w0", bus.m_o[31:0], 32'h03020100);
    check("s_ready_never_low", ready_low_seen, 0);
    step();
    check("s_drained", bus.blk_v_o, 0);
    check("s_no_err", bus.err_o, 0);

    // Backpressure: two blocks queue up, the third stalls
    bus.blk_ready_i = 1'b0;
    bus.ll_i = 64'd200;
    for (int i = 0; i < 64; i++) pat[i] = 8'(i + 8'h40);
    blk_a = pat_m();
    send_range(0, 63, 1'b1, 1'b0);
    check("bp_a_v", bus.blk_v_o, 1);
    check("bp_a_ready", bus.ready_o, 1);
    for (int i = 0; i < 64; i++) pat[i] = 8'(8'hff - i);
    blk_b = pat_m();
    send_range(0, 63, 1'b0, 1'b0);
    check("bp_full_ready", bus.ready_o, 0);
    check("bp_a_still_t", bus.t_o, 64);
    check("bp_a_still_m", bus.m_o, blk_a);
    send_byte(0, 8'haa, 1'b0, 1'b0);
    check("bp_drop_err", bus.err_o, 1);
    check("bp_drop_ready", bus.ready_o, 0);
    bus.blk_ready_i = 1'b1;
    step();
    check("bp_b_v", bus.blk_v_o, 1);
    check("bp_b_ready", bus.ready_o, 1);
    check("bp_b_t", bus.t_o, 128);
    check("bp_b_m", bus.m_o, blk_b);
    step();
    check("bp_drained", bus.blk_v_o, 0);
    bus.blk_ready_i = 1'b0;

    // Keyed single block, empty message
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    check("key_err_cleared", bus.err_o, 0);
    bus.kk_i = 6'd32;
    bus.ll_i = 64'd0;
    for (int i = 0; i < 64; i++) pat[i] = (i < 32) ? 8'h11 : 8'h00;
    send_range(0, 63, 1'b1, 1'b1);
    check("key_v", bus.blk_v_o, 1);
    check("key_t", bus.t_o, 64);
    check("key_last", bus.last_o, 1);
    check("key_no_err", bus.err_o, 0);
    bus.blk_ready_i = 1'b1;
    step();
    bus.blk_ready_i = 1'b0;

    // Index skip: idx 3 arrives while 2 is expected
    bus.kk_i = 6'd0;
    bus.ll_i = 64'd64;
    for (int i = 0; i < 64; i++) pat[i] = 8'(i + 8'h10);
    send_range(0, 1, 1'b1, 1'b1);
    check("skip_pre_err", bus.err_o, 0);
    send_byte(3, 8'h99, 1'b0, 1'b1);
    check("skip_err", bus.err_o, 1);
    send_range(2, 62, 1'b0, 1'b1);
    check("skip_not_done", bus.blk_v_o, 0);
    send_range(63, 63, 1'b0, 1'b1);
    check("skip_v", bus.blk_v_o, 1);
    check("skip_w0", bus.m_o[31:0], 32'h13121110);
    check("skip_m", bus.m_o, pat_m());
    check("skip_t", bus.t_o, 64);
    bus.blk_ready_i = 1'b1;
    step();
    bus.blk_ready_i = 1'b0;

    // Reset in the middle of a block
    for (int i = 0; i < 64; i++) pat[i] = 8'(i + 5);
    send_range(0, 40, 1'b1, 1'b0);
    nreset = 1'b0;
    step();
    check("mid_rst_v", bus.blk_v_o, 0);
    check("mid_rst_ready", bus.ready_o, 1);
    check("mid_rst_err", bus.err_o, 0);
    nreset = 1'b1;
    step();
    step();
    check("mid_rst_no_partial", bus.blk_v_o, 0);
    bus.ll_i = 64'd500;
    send_range(0, 63, 1'b1, 1'b0);
    check("fresh_v", bus.blk_v_o, 1);
    check("fresh_t", bus.t_o, 64);
    check("fresh_last", bus.last_o, 0);
    check("fresh_m", bus.m_o, pat_m());
    check("fresh_no_err", bus.err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2s_msg_buf.md
# blake2s_msg_buf

Byte-to-block buffer sitting directly downstream of the I/O interface's block-data path. It collects the serial byte stream (`data_v`/`data`/`data_idx`/`block_first`/`block_last`) into 64-byte BLAKE2s message blocks of sixteen little-endian 32-bit words. It computes the offset counter `t` and the final-block flag, and hands each complete block to the compression core over a valid/ready handshake. Two stages (fill and output) let the host stream the next block while the core consumes the current one; `ready_o` feeds the interface's `ready_v_i`.

## Interface
Parameters:
- `BLOCK_BYTES`, 64, bytes per message block; fixed for BLAKE2s.
- `WORD_W`, 32, message word width.

Ports:
- `clk`  in  1  clock.
- `nreset`  in  1  reset; synchronous, active-low.
- `data_v_i`  in  1  byte valid.
- `data_i`  in  8  byte value.
- `data_idx_i`  in  6  byte index within block, 0..63.
- `block_first_i`  in  1  current block is the first of the message; sampled with idx 0.
- `block_last_i`  in  1  current block is the final block; sampled with idx 63.
- `kk_i`  in  6  key length in bytes; 0 means unkeyed.
- `ll_i`  in  64  message length in bytes.
- `ready_o`  out  1  fill stage can accept bytes.
- `blk_v_o`  out  1  output block valid.
- `blk_ready_i`  in  1  core accepts the block.
- `m_o`  out  512  message words; m[k] = `m_o[32k+:32]`.
- `t_o`  out  64  offset counter for this block.
- `last_o`  out  1  final block; the core sets f0 = all ones.
- `err_o`  out  1  sticky protocol error.

## Operation
- Byte packing: byte at idx i goes to word i/4, bits `[8*(i%4)+:8]`. The host sends all 64 bytes, including zero padding; the block does no padding.
- Fill stage:
  - FILLING: expected index `exp_q` starts at 0 and increments on each accepted byte.
  - Byte with idx 63 accepted: enter FULL and latch `block_last_i` as `last`.
- Transfer from fill to output occurs when FULL and (output EMPTY, or output VALID with `blk_ready_i`). The fill stage returns to FILLING with `exp_q` = 0. Words are not cleared; every byte is overwritten.
- Output stage:
  - EMPTY→VALID on transfer.
  - VALID→EMPTY on `blk_ready_i` with no simultaneous transfer.
  - VALID with `blk_ready_i` and simultaneous transfer stays VALID with the new block.
- `t` accumulator `t_acc_q` (64-bit, wraps mod 2^64):
  - Reset to 0 when byte idx 0 arrives with `block_first_i`=1.
  - On each transfer: non-last blocks get `t_o` = `t_acc_q` + 64, then `t_acc_q` += 64.
  - Last blocks get `t_o` = `ll_i` + (`kk_i`≠0 ? 64 : 0).
- `ready_o` = ~FULL. It is combinational from state only, never from `data_v_i`.
- Error cases; `err_o` is sticky, cleared only by reset:
  - Byte arrives while FULL: byte dropped, error set.
  - `data_idx_i` ≠ `exp_q`: byte dropped, error set.
  - `block_first_i`=1 with idx ≠ 0: error set, byte still stored.

## Timing
- Reset values: `blk_v_o`=0, `ready_o`=1, `err_o`=0, `last_o`=0, `t_o`=0, `m_o`=0. Both stages EMPTY/FILLING, `exp_q`=0, `t_acc_q`=0.
- Latency: idx-63 byte accepted in cycle N; with output EMPTY, `blk_v_o`=1 in cycle N+1. With output VALID and no `blk_ready_i`, `ready_o`=0 from N+1.
- `m_o`, `t_o` and `last_o` are stable while `blk_v_o`=1 and `blk_ready_i`=0.
- Simultaneous events:
  - FULL, output VALID and `blk_ready_i` in the same cycle: transfer that cycle. `ready_o`=1 next cycle, and `blk_v_o` stays 1 with the new block.
  - Byte idx 63 accepted in the same cycle as output handshake: the output goes EMPTY next cycle, and the fill stage is FULL next cycle. Transfer happens in cycle N+1, so the block appears at N+2.
- Reset mid-block discards both stages with no output. A partial block is never emitted.

## Structure
- `blake2s_pkg`:
  - constants: `BLOCK_BYTES`, `WORD_W`, `NWORDS`=16, `T_W`=64.
  - enums: fill state (FILLING, FULL) and output state (EMPTY, VALID).
- One sub-module, `msg_word_packer`: 64-byte register file with byte-lane write enable decoded from idx and a flat 512-bit read. Instantiated once as the fill stage. The output stage is a plain 512-bit register loaded on transfer.

## Test plan
- Unkeyed single block: `kk_i`=0, `ll_i`=3, bytes 0x61,0x62,0x63 then 61 zeros with first=last=1 → one block, m[0]=0x00636261, m[1..15]=0, `t_o`=3, `last_o`=1, `blk_v_o` one cycle after idx 63.
- Three-block stream, `blk_ready_i` always 1, `ll_i`=150, bytes = idx value → `t_o` = 64, 128, 150; `last_o` only on the third block; m[0]=0x03020100 on every block; `ready_o` never low.
- Backpressure: `blk_ready_i`=0, two full blocks sent → `ready_o`=0 after the second block's idx 63. A third-block byte during this sets `err_o`=1 and is dropped. Raise `blk_ready_i` → first block pops, and the second appears the next cycle with `ready_o` back to 1.
- Keyed, `kk_i`=32, `ll_i`=0, single key block with last=1 → `t_o`=64, `last_o`=1.
- Index skip: idx 0,1,3 → `err_o`=1, idx-3 byte dropped, `exp_q` stays 2; resending idx 2..63 completes the block.
- Reset asserted after idx 40 → `blk_v_o`=0 and `ready_o`=1 the next cycle. A fresh block then completes normally with `t` restarted.
